// File: rtl/dma_engine_if.sv
// Bus bundle for the word-copy DMA: the south-bridge responder port plus the
// arbiter-granted initiator port. "slave" is the DMA device's view; "master"
// is the system side (bridge, arbiter and memory) that drives it.
interface dma_engine_if;
  logic [31:0] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;
  logic        MReq;
  logic        MGnt;
  logic [31:0] MAddr;
  logic        MWE;
  logic [31:0] MWD;
  logic [31:0] MRD;

  modport slave (
    input  Addr, WE, Din, MGnt, MRD,
    output Dout, IRQ, MReq, MAddr, MWE, MWD
  );

  modport master (
    output Addr, WE, Din, MGnt, MRD,
    input  Dout, IRQ, MReq, MAddr, MWE, MWD
  );
endinterface

// File: rtl/dma_engine.sv
// Word-copy DMA engine. The CPU programs SRC/DST/LEN through the responder
// port and starts a copy via CTRL; the engine then alternates one read beat
// and one write beat per word on the initiator port and raises IRQ when done.
module dma_engine (
  input  logic         clk,
  input  logic         reset,
  dma_engine_if.slave  bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] src_q, src_d;
  logic [31:0] dst_q, dst_d;
  logic [31:0] len_q, len_d;
  logic [31:0] buf_q, buf_d;
  logic        im_q, im_d;
  logic        done_q, done_d;
  logic        busy;
  logic        unused_addr;

  assign busy        = (state_q != IDLE);
  assign unused_addr = ^{bus.Addr[31:4], bus.Addr[1:0]};

  // Next-state: a CPU register write takes priority over any granted beat
  // on the same edge, so a colliding beat is simply dropped.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    buf_d   = buf_q;
    im_d    = im_q;
    done_d  = done_q;

    if (state_q == 2'd3) begin
      state_d = IDLE;
    end else if (bus.WE) begin
      case (bus.Addr[3:2])
        2'd0: begin
          im_d = bus.Din[1];
          if (bus.Din[2]) begin
            done_d = 1'b0;
          end
          if (!busy) begin
            if (bus.Din[0]) begin
              if (len_q != 32'd0) begin
                done_d  = 1'b0;
                state_d = READ;
              end else begin
                done_d = 1'b1;
              end
            end
          end else if (!bus.Din[0]) begin
            state_d = IDLE;
          end
        end
        2'd1: begin
          if (!busy) begin
            src_d = {bus.Din[31:2], 2'b00};
          end
        end
        2'd2: begin
          if (!busy) begin
            dst_d = {bus.Din[31:2], 2'b00};
          end
        end
        default: begin
          if (!busy) begin
            len_d = bus.Din;
          end
        end
      endcase
    end else if (bus.MGnt) begin
      case (state_q)
        READ: begin
          buf_d   = bus.MRD;
          state_d = WRITE;
        end
        WRITE: begin
          src_d = src_q + 32'd4;
          dst_d = dst_q + 32'd4;
          len_d = (len_q != 32'd0) ? (len_q - 32'd1) : 32'd0;
          if (len_d == 32'd0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = READ;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // State and register flops, cleared asynchronously so reset cancels a beat at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= 32'd0;
      dst_q   <= 32'd0;
      len_q   <= 32'd0;
      buf_q   <= 32'd0;
      im_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      buf_q   <= buf_d;
      im_q    <= im_d;
      done_q  <= done_d;
    end
  end

  // Bus outputs and register read-back, all decoded from current state.
  always_comb begin
    bus.MReq  = busy;
    bus.MWE   = (state_q == WRITE);
    bus.MAddr = 32'd0;
    bus.MWD   = 32'd0;
    bus.IRQ   = done_q & im_q;
    bus.Dout  = 32'd0;

    if (state_q == READ) begin
      bus.MAddr = src_q;
    end else if (state_q == WRITE) begin
      bus.MAddr = dst_q;
      bus.MWD   = buf_q;
    end

    case (bus.Addr[3:2])
      2'd0:    bus.Dout = {29'd0, done_q, im_q, busy};
      2'd1:    bus.Dout = src_q;
      2'd2:    bus.Dout = dst_q;
      default: bus.Dout = len_q;
    endcase
  end

endmodule

// File: tb/tb_dma_engine.sv
// Directed bench for dma_engine: a small word memory answers the initiator
// port, and every expected value below is a hand-computed constant.
module tb_dma_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        preload_en;
  logic [9:0]  preload_idx;
  logic [31:0] preload_data;
  logic [31:0] mem [0:1023];
  logic [31:0] rd;
  logic [31:0] saved_maddr;
  logic [31:0] saved_mwd;
  logic        saved_mwe;
  logic [9:0]  pat;
  int          compared;
  int          mismatched;

  dma_engine_if bus ();

  dma_engine u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running system clock.
  always #5 clk = ~clk;

  // Memory read data is combinational from the word address.
  assign bus.MRD = mem[bus.MAddr[11:2]];

  // Memory write port: bench preload, otherwise granted DMA write beats.
  always @(posedge clk) begin
    if (preload_en) begin
      mem[preload_idx] <= preload_data;
    end else if (bus.MReq && bus.MGnt && bus.MWE) begin
      mem[bus.MAddr[11:2]] <= bus.MWD;
    end
  end

  // Run-away guard so the bench always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_reg(input logic [1:0] idx, input logic [31:0] data);
    bus.Addr = {28'd0, idx, 2'b00};
    bus.Din  = data;
    bus.WE   = 1'b1;
    @(posedge clk);
    #1;
    bus.WE   = 1'b0;
  endtask

  task automatic check_reg(input string tag, input logic [1:0] idx, input logic [31:0] exp);
    bus.Addr = {28'd0, idx, 2'b00};
    bus.WE   = 1'b0;
    #1;
    rd = bus.Dout;
    check_output(tag, rd, exp);
  endtask

  task automatic preload(input logic [9:0] idx, input logic [31:0] data);
    preload_idx  = idx;
    preload_data = data;
    preload_en   = 1'b1;
    @(posedge clk);
    #1;
    preload_en   = 1'b0;
  endtask

  // Linear directed sequence.
  initial begin
    compared     = 0;
    mismatched   = 0;
    reset        = 1'b1;
    preload_en   = 1'b0;
    preload_idx  = 10'd0;
    preload_data = 32'd0;
    bus.Addr     = 32'd0;
    bus.WE       = 1'b0;
    bus.Din      = 32'd0;
    bus.MGnt     = 1'b1;
    pat          = 10'b1101101001;

    // Reset with grant held high.
    step(2);
    check_output("rst_mreq", {31'd0, bus.MReq}, 32'd0);
    check_output("rst_mwe", {31'd0, bus.MWE}, 32'd0);
    check_output("rst_irq", {31'd0, bus.IRQ}, 32'd0);
    check_output("rst_maddr", bus.MAddr, 32'd0);
    check_reg("rst_ctrl", 2'd0, 32'd0);
    check_reg("rst_src", 2'd1, 32'd0);
    check_reg("rst_dst", 2'd2, 32'd0);
    check_reg("rst_len", 2'd3, 32'd0);
    reset = 1'b0;
    bus.MGnt = 1'b0;
    step(1);

    preload(10'd64, 32'h11);
    preload(10'd65, 32'h22);
    preload(10'd66, 32'h33);

    // Basic three-word copy with grant always high.
    write_reg(2'd1, 32'h100);
    write_reg(2'd2, 32'h200);
    write_reg(2'd3, 32'd3);
    bus.MGnt = 1'b1;
    write_reg(2'd0, 32'h3);
    check_output("copy_mreq_e1", {31'd0, bus.MReq}, 32'd1);
    check_output("copy_maddr_e1", bus.MAddr, 32'h100);
    step(5);
    check_output("copy_irq_e5", {31'd0, bus.IRQ}, 32'd0);
    check_output("copy_maddr_e5", bus.MAddr, 32'h208);
    check_output("copy_mwd_e5", bus.MWD, 32'h33);
    step(1);
    check_output("copy_irq_e6", {31'd0, bus.IRQ}, 32'd1);
    check_output("copy_mreq_e6", {31'd0, bus.MReq}, 32'd0);
    check_output("copy_mem0", mem[128], 32'h11);
    check_output("copy_mem1", mem[129], 32'h22);
    check_output("copy_mem2", mem[130], 32'h33);
    check_reg("copy_src", 2'd1, 32'h10C);
    check_reg("copy_dst", 2'd2, 32'h20C);
    check_reg("copy_len", 2'd3, 32'd0);
    check_reg("copy_ctrl", 2'd0, 32'h6);
    write_reg(2'd0, 32'h4);
    check_output("clr_irq", {31'd0, bus.IRQ}, 32'd0);
    check_reg("clr_ctrl", 2'd0, 32'h0);

    // Same copy with an irregular grant pattern.
    bus.MGnt = 1'b0;
    write_reg(2'd1, 32'h100);
    write_reg(2'd2, 32'h300);
    write_reg(2'd3, 32'd3);
    write_reg(2'd0, 32'h3);
    for (int j = 0; j < 10; j++) begin
      bus.MGnt    = pat[j];
      saved_maddr = bus.MAddr;
      saved_mwe   = bus.MWE;
      saved_mwd   = bus.MWD;
      step(1);
      if (!pat[j]) begin
        check_output("stall_maddr", bus.MAddr, saved_maddr);
        check_output("stall_mwe", {31'd0, bus.MWE}, {31'd0, saved_mwe});
        check_output("stall_mwd", bus.MWD, saved_mwd);
      end
      check_output("stall_irq", {31'd0, bus.IRQ}, (j == 9) ? 32'd1 : 32'd0);
    end
    check_output("stall_mreq_end", {31'd0, bus.MReq}, 32'd0);
    check_output("stall_mem0", mem[192], 32'h11);
    check_output("stall_mem1", mem[193], 32'h22);
    check_output("stall_mem2", mem[194], 32'h33);
    write_reg(2'd0, 32'h4);

    // Zero-length start completes at once with no bus request.
    write_reg(2'd3, 32'd0);
    bus.MGnt = 1'b1;
    write_reg(2'd0, 32'h3);
    check_output("zero_mreq", {31'd0, bus.MReq}, 32'd0);
    check_output("zero_irq", {31'd0, bus.IRQ}, 32'd1);
    check_reg("zero_ctrl", 2'd0, 32'h6);
    step(2);
    check_output("zero_mreq_later", {31'd0, bus.MReq}, 32'd0);
    write_reg(2'd0, 32'h4);
    check_output("zero_irq_clr", {31'd0, bus.IRQ}, 32'd0);

    // Abort after the first write beat.
    bus.MGnt = 1'b0;
    write_reg(2'd1, 32'h100);
    write_reg(2'd2, 32'h400);
    write_reg(2'd3, 32'd3);
    bus.MGnt = 1'b1;
    write_reg(2'd0, 32'h1);
    step(2);
    bus.MGnt = 1'b0;
    write_reg(2'd0, 32'h0);
    check_output("abort_mreq", {31'd0, bus.MReq}, 32'd0);
    check_reg("abort_len", 2'd3, 32'd2);
    check_reg("abort_src", 2'd1, 32'h104);
    check_reg("abort_dst", 2'd2, 32'h404);
    check_reg("abort_ctrl", 2'd0, 32'h0);
    check_output("abort_mem", mem[256], 32'h11);

    // Register writes while busy are ignored.
    write_reg(2'd1, 32'h100);
    write_reg(2'd2, 32'h500);
    write_reg(2'd3, 32'd2);
    write_reg(2'd0, 32'h3);
    write_reg(2'd3, 32'd9);
    write_reg(2'd1, 32'h800);
    check_reg("busy_len", 2'd3, 32'd2);
    check_reg("busy_src", 2'd1, 32'h100);
    check_reg("busy_ctrl", 2'd0, 32'h3);
    bus.MGnt = 1'b1;
    step(4);
    check_output("busy_irq", {31'd0, bus.IRQ}, 32'd1);
    check_output("busy_mem0", mem[320], 32'h11);
    check_output("busy_mem1", mem[321], 32'h22);
    bus.MGnt = 1'b0;
    write_reg(2'd0, 32'h4);

    // Source address wraps from the top of memory to zero.
    preload(10'd1023, 32'hAA);
    preload(10'd0, 32'hBB);
    write_reg(2'd1, 32'hFFFF_FFFF);
    check_reg("wrap_src_align", 2'd1, 32'hFFFF_FFFC);
    write_reg(2'd2, 32'h600);
    write_reg(2'd3, 32'd2);
    bus.MGnt = 1'b1;
    write_reg(2'd0, 32'h1);
    check_output("wrap_maddr0", bus.MAddr, 32'hFFFF_FFFC);
    step(2);
    check_output("wrap_maddr1", bus.MAddr, 32'h0);
    step(2);
    check_output("wrap_mem0", mem[384], 32'hAA);
    check_output("wrap_mem1", mem[385], 32'hBB);
    check_reg("wrap_src", 2'd1, 32'h4);
    check_reg("wrap_ctrl", 2'd0, 32'h4);
    check_output("wrap_irq_masked", {31'd0, bus.IRQ}, 32'd0);
    bus.MGnt = 1'b0;
    write_reg(2'd0, 32'h4);

    // Reset during a granted write beat.
    preload(10'd448, 32'hDEAD);
    write_reg(2'd1, 32'h100);
    write_reg(2'd2, 32'h700);
    write_reg(2'd3, 32'd3);
    bus.MGnt = 1'b1;
    write_reg(2'd0, 32'h3);
    step(1);
    check_output("rstmid_mwe_before", {31'd0, bus.MWE}, 32'd1);
    reset = 1'b1;
    #1;
    check_output("rstmid_mreq", {31'd0, bus.MReq}, 32'd0);
    check_output("rstmid_mwe", {31'd0, bus.MWE}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_output("rstmid_mem", mem[448], 32'hDEAD);
    check_reg("rstmid_len", 2'd3, 32'd0);
    check_reg("rstmid_src", 2'd1, 32'd0);
    step(2);
    check_output("rstmid_mreq_later", {31'd0, bus.MReq}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dma_engine.md
# dma_engine

Word-copy DMA device for the system bus. It sits behind the south bridge as an ordinary memory-mapped responder, using the same Addr/WE/Din/Dout/IRQ port set as the timer devices. It also carries a second, initiator-side port that the bus arbiter grants when the CPU is idle. Once programmed by the CPU, it copies LEN words from SRC to DST on its own, then raises IRQ on the south bridge HWInt line it is wired to.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- Addr  in  32  slave register address; only Addr[3:2] decoded
- WE  in  1  slave write enable, from south bridge
- Din  in  32  slave write data
- Dout  out  32  slave read data, combinational from Addr[3:2]
- IRQ  out  1  interrupt request, level: done & IM
- MReq  out  1  master bus request
- MGnt  in  1  arbiter grant; a beat completes on any edge where MReq & MGnt
- MAddr  out  32  master word address, low 2 bits always 0
- MWE  out  1  master write enable; qualified by MGnt
- MWD  out  32  master write data
- MRD  in  32  master read data, valid combinationally in a granted read cycle

## Operation
- Register map, selected by Addr[3:2]:
  - 0 CTRL: bit0 busy/start, bit1 IM, bit2 done.
  - 1 SRC.
  - 2 DST.
  - 3 LEN, in words; reads return the remaining count.
- CTRL read value is {29'b0, done, IM, busy}.
- Write to CTRL while IDLE:
  - IM <= Din[1].
  - If Din[2] = 1, clear done (write-1-to-clear).
  - If Din[0] = 1 and LEN != 0: clear done and go to READ.
  - If Din[0] = 1 and LEN == 0: set done and stay IDLE; no bus activity.
- Writes to SRC and DST store Din with bits [1:0] forced to 0.
- While busy, writes to SRC, DST and LEN are ignored.
- Write to CTRL while busy:
  - IM and the done clear are applied.
  - Din[0] = 0 aborts: go to IDLE at that edge and keep the remaining SRC, DST and LEN.
  - Abort does not set done.
- FSM states: IDLE, READ, WRITE.
  - IDLE: MReq = 0, MWE = 0.
  - READ: MReq = 1, MWE = 0, MAddr = SRC. On a granted edge: buf <= MRD, go to WRITE.
  - WRITE: MReq = 1, MWE = 1, MAddr = DST, MWD = buf. On a granted edge: SRC += 4, DST += 4, LEN -= 1. Then go to IDLE and set done if the new LEN is 0, otherwise go to READ.
- Without a grant, READ and WRITE hold, and MAddr, MWE and MWD stay stable.
- Address arithmetic is 32-bit modulo: 0xFFFFFFFC + 4 = 0x00000000. LEN decrement never underflows.
- If the slave WE and a granted beat happen on the same edge, the register write wins. The beat is discarded with no state advance and no SRC, DST or LEN change. The arbiter normally prevents this case.
- Overlapping regions are copied in ascending order, one word at a time; no overlap correction.

## Timing
- Reset values:
  - Registers: SRC = DST = LEN = 0; IM = done = busy = 0; buf = 0.
  - State: IDLE.
  - Outputs: MReq, MWE, IRQ = 0; MAddr, MWD = 0.
  - Dout follows the combinational decode (0 for every address after reset).
- A start write commits at edge E0. MReq is high in the cycle after E0.
- With MGnt held at 1, each word takes 2 cycles:
  - the read beat completes at edge E0+(2k-1);
  - the write beat completes at edge E0+2k.
- For N words, done and IRQ (when IM = 1) are high after edge E0+2N, and MReq is low in that same cycle.
- Each cycle without a grant adds exactly one cycle of latency.
- Reset asserted mid-transfer returns to reset values immediately, with no further beats. A write beat that is granted in the same cycle as the reset does not take effect.
- IRQ is a level signal: it drops on the edge where done is cleared or IM is written to 0.

## Test plan
- Reset check: assert reset with MGnt = 1 -> MReq = MWE = IRQ = 0, and every register reads 0.
- Basic copy: memory model has 0x100 = 0x11, 0x104 = 0x22, 0x108 = 0x33. Program SRC = 0x100, DST = 0x200, LEN = 3, CTRL = 0x3, with MGnt = 1 -> 0x200/0x204/0x208 hold 0x11/0x22/0x33. Done and IRQ are set 6 cycles after the start edge. Reads return SRC = 0x10C, DST = 0x20C, LEN = 0, CTRL = 0x6.
- Grant stalls: same copy with MGnt = 1,0,0,1,0,1,... -> MAddr, MWE and MWD are stable across every stall, data is correct, and completion is delayed by exactly the number of ungranted cycles.
- Zero length: LEN = 0, CTRL = 0x3 -> MReq never asserts, and done and IRQ are high one edge later.
- Abort: LEN = 3, CTRL = 0x1; after the first write beat, write CTRL = 0 -> MReq is low the next cycle, LEN reads 2, SRC = 0x104, done = 0.
- Busy and interrupt handling:
  - Writing LEN = 9 while busy is ignored.
  - Writing CTRL = 0x4 after completion clears done and IRQ.
  - SRC = 0xFFFFFFFC with LEN = 2 wraps the second read to 0x0.
  - Reset mid-transfer drops MReq immediately.
